uc_rr_scheduler: RTL and testbench
==================================

# uc_rr_scheduler

Round-robin scheduler that sits between the per-engine implied-unit-clause queues and the unit-clause arbiter's engine input. It selects one non-empty engine queue per grant, pops its head literal into a registered output stage with valid/ready handshake, and detects global quiescence (all queues empty, no engine busy) to end a propagation round. A conflict abort from the arbiter terminates the round immediately.

## Interface
- NUM_ENGINE, 4, number of engine queues (≥2)
- LIT_W, $clog2(`LIT_IDX_MAX)+1, signed literal width (MSB = polarity)
- IDLE_LIMIT, 4, consecutive quiescent cycles required to declare done (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level-sampled pulse; begins a round from IDLE or DONE
- abort  in  1  conflict reported by arbiter; ends round
- eng_empty  in  NUM_ENGINE  per-engine queue empty
- eng_busy  in  NUM_ENGINE  per-engine still propagating
- eng_lit  in  NUM_ENGINE*LIT_W  head literal of each queue, engine i at [i*LIT_W +: LIT_W]
- eng_pop  out  NUM_ENGINE  one-hot pop, combinational from grant
- sched_valid  out  1  output literal valid
- sched_lit  out  LIT_W  signed literal to arbiter
- sched_ready  in  1  arbiter accepts literal
- grant_idx  out  $clog2(NUM_ENGINE)  index of last granted engine
- done  out  1  round finished (quiescent or aborted)
- aborted  out  1  round ended by abort

## Operation
- FSM states: IDLE, RUN, DONE (encoding in package).
- IDLE: no pops; start → RUN, clear quiescence counter, rr pointer = 0.
- RUN: grant allowed when output stage free or freeing this cycle (sched_valid=0, or sched_valid & sched_ready).
- Grant: first engine i with eng_empty[i]=0 searching pointer, pointer+1, … wrapping mod NUM_ENGINE; assert eng_pop[i]; capture eng_lit[i] into sched_lit, set sched_valid next cycle; pointer ← i+1 (wraps NUM_ENGINE-1 → 0); grant_idx ← i.
- No eligible engine: no pop; sched_valid cleared if accepted this cycle.
- sched_valid & !sched_ready: sched_lit, sched_valid held stable; no pop.
- Quiescence: counter increments when &eng_empty, ~|eng_busy, sched_valid=0; otherwise resets to 0; saturates at IDLE_LIMIT. Counter reaching IDLE_LIMIT → DONE, done=1, aborted=0.
- abort in RUN (highest priority): no pop that cycle, sched_valid cleared, → DONE, aborted=1.
- DONE: no pops, sched_valid=0, done/aborted held; start → RUN with aborted cleared, counter and pointer reset. abort in IDLE/DONE ignored.

## Timing
- Reset values: eng_pop=0, sched_valid=0, sched_lit=0, grant_idx=0, done=0, aborted=0, state=IDLE, pointer=0, counter=0.
- Grant-to-valid latency 1 cycle; sustained throughput one literal per cycle when sched_ready held high and queues non-empty.
- eng_pop is combinational from registered state and current eng_empty/sched_ready; never asserted for an empty queue.
- Quiescence detected IDLE_LIMIT cycles after last activity; done rises the following edge.
- start and abort same cycle in RUN: abort wins. start in RUN ignored.
- Reset mid-round: all outputs return to reset values asynchronously; in-flight literal discarded.

## Structure
- Shared package: state enum, LIT_W-based literal typedef, pointer width constant.
- One sub-module natural: rr_pick (combinational rotating priority encoder, inputs request vector and pointer, outputs one-hot grant and index).

## Test plan
- NUM_ENGINE=4, all queues hold 2 literals, ready=1 → pops engines 0,1,2,3,0,1,2,3 on consecutive cycles; sched_lit sequence matches.
- Only engine 2 non-empty, pointer=3 → wrap search grants engine 2; pointer becomes 3.
- sched_valid=1 with literal -5, sched_ready low 3 cycles → sched_lit stays -5, no eng_pop; ready high → next grant same cycle.
- All empty, no busy, IDLE_LIMIT=4 → done=1 exactly 5 cycles after last acceptance; busy blip at cycle 2 restarts count.
- abort while sched_valid=1 → next cycle sched_valid=0, done=1, aborted=1, no further pops; start → RUN, aborted=0.
- rst asserted mid-burst → all outputs zero immediately, state IDLE.

Source files
------------

// File: rtl/uc_rr_scheduler_pkg.sv
// uc_rr_scheduler_pkg: shared types and constants
// for the unit-clause round-robin scheduler.
package uc_rr_scheduler_pkg;

  localparam int LIT_IDX_MAX = 1023;

  localparam int LIT_W_DEF = $clog2(LIT_IDX_MAX) + 1;

  localparam int NUM_ENGINE_DEF = 4;
  localparam int PTR_W_DEF      = $clog2(NUM_ENGINE_DEF);

  typedef logic signed [LIT_W_DEF-1:0] lit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/uc_rr_scheduler_rr_pick.sv
// uc_rr_scheduler_rr_pick: rotating priority encoder.
// Ports: req (request vector), ptr (highest-priority index),
//        gnt (one-hot grant), idx (granted index), any (some request).
module uc_rr_scheduler_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    localparam logic [PTR_W:0] N_L = (PTR_W + 1)'(N);

    // One extra bit so ptr + k can be folded back into 0..N-1
    // without relying on N being a power of two.
    logic [PTR_W:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (pos >= N_L) begin
                pos = pos - N_L;
            end
            if (!any && req[pos[PTR_W-1:0]]) begin
                any                  = 1'b1;
                idx                  = pos[PTR_W-1:0];
                gnt[pos[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uc_rr_scheduler.sv
// uc_rr_scheduler: round-robin pop of per-engine unit-clause queues into a
// registered valid/ready output stage, with quiescence and abort detection.
// Ports: clk, rst (async high), start, abort, eng_empty/eng_busy/eng_lit
//        (per-engine queue heads), eng_pop (one-hot), sched_valid/lit/ready
//        (output handshake), grant_idx, done, aborted.
module uc_rr_scheduler
    import uc_rr_scheduler_pkg::*;
#(
    parameter int NUM_ENGINE = 4,
    parameter int LIT_W      = LIT_W_DEF,
    parameter int IDLE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_ENGINE-1:0]         eng_empty,
    input  logic [NUM_ENGINE-1:0]         eng_busy,
    input  logic [NUM_ENGINE*LIT_W-1:0]   eng_lit,
    output logic [NUM_ENGINE-1:0]         eng_pop,
    output logic                          sched_valid,
    output logic signed [LIT_W-1:0]       sched_lit,
    input  logic                          sched_ready,
    output logic [$clog2(NUM_ENGINE)-1:0] grant_idx,
    output logic                          done,
    output logic                          aborted
);

    localparam int PTR_W = $clog2(NUM_ENGINE);
    localparam int CNT_W = $clog2(IDLE_LIMIT + 1);

    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_ENGINE - 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(IDLE_LIMIT);

    state_e                    state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      valid_q, valid_d;
    logic signed [LIT_W-1:0]   lit_q, lit_d;
    logic [PTR_W-1:0]          gidx_q, gidx_d;
    logic                      done_q, done_d;
    logic                      aborted_q, aborted_d;

    logic [NUM_ENGINE-1:0]     pick_gnt;
    logic [PTR_W-1:0]          pick_idx;
    logic                      pick_any;
    logic signed [LIT_W-1:0]   pick_lit;
    logic [PTR_W-1:0]          ptr_next;
    logic                      quiet;
    logic                      finishing;
    logic                      grant_en;

    uc_rr_scheduler_rr_pick #(
        .N     (NUM_ENGINE),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (~eng_empty),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        pick_lit = '0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (pick_gnt[i]) begin
                pick_lit = eng_lit[i*LIT_W +: LIT_W];
            end
        end
    end

    assign ptr_next  = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
    assign quiet     = (&eng_empty) && !(|eng_busy) && !valid_q;
    // The round ends this cycle; a late arrival must stay queued
    // rather than be popped into a stage that is about to be cleared.
    assign finishing = (cnt_q == LIMIT);
    assign grant_en  = (state_q == ST_RUN) && !abort && !finishing &&
                       pick_any && (!valid_q || sched_ready);
    assign eng_pop   = grant_en ? pick_gnt : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        lit_d     = lit_q;
        gidx_d    = gidx_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    ptr_d   = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    valid_d   = 1'b0;
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    if (grant_en) begin
                        valid_d = 1'b1;
                        lit_d   = pick_lit;
                        gidx_d  = pick_idx;
                        ptr_d   = ptr_next;
                    end else if (valid_q && sched_ready) begin
                        valid_d = 1'b0;
                    end
                    if (!quiet) begin
                        cnt_d = '0;
                    end else if (cnt_q != LIMIT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (finishing) begin
                        state_d   = ST_DONE;
                        valid_d   = 1'b0;
                        done_d    = 1'b1;
                        aborted_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d   = ST_RUN;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    cnt_d     = '0;
                    ptr_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            lit_q     <= '0;
            gidx_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            lit_q     <= lit_d;
            gidx_q    <= gidx_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign sched_valid = valid_q;
    assign sched_lit   = lit_q;
    assign grant_idx   = gidx_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_uc_rr_scheduler.sv
// tb_uc_rr_scheduler: scenario tasks driving modelled engine queues,
// with a scoreboard of expected (literal, engine) pairs per acceptance.
module tb_uc_rr_scheduler;
    import uc_rr_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int LW = LIT_W_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          sched_ready = 1'b0;
    logic [N-1:0]  eng_busy = '0;
    logic [N-1:0]  eng_empty;
    logic [N*LW-1:0] eng_lit;
    logic [N-1:0]  eng_pop;
    logic [N-1:0]  pop_s = '0;
    logic          sched_valid;
    lit_t          sched_lit;
    logic [1:0]    grant_idx;
    logic          done;
    logic          aborted;

    lit_t mem [N][64];
    int   wr  [N] = '{default: 0};
    int   rd  [N] = '{default: 0};

    typedef struct {
        lit_t       lit;
        logic [1:0] idx;
    } exp_t;
    exp_t expq[$];

    int checks = 0;
    int errors = 0;

    uc_rr_scheduler #(
        .NUM_ENGINE (N),
        .LIT_W      (LW),
        .IDLE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .eng_empty   (eng_empty),
        .eng_busy    (eng_busy),
        .eng_lit     (eng_lit),
        .eng_pop     (eng_pop),
        .sched_valid (sched_valid),
        .sched_lit   (sched_lit),
        .sched_ready (sched_ready),
        .grant_idx   (grant_idx),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    always_comb begin
        eng_empty = '1;
        eng_lit   = '0;
        for (int i = 0; i < N; i++) begin
            eng_empty[i]          = (rd[i] == wr[i]);
            eng_lit[i*LW +: LW]   = mem[i][rd[i][5:0]];
        end
    end

    // Engine queue model: pops seen before an edge take effect at it.
    always @(negedge clk) begin
        pop_s = eng_pop;
        for (int i = 0; i < N; i++) begin
            if (eng_pop[i]) begin
                checks++;
                if (eng_empty[i]) begin
                    errors++;
                    $display("FAIL pop_empty: engine %0d popped while empty", i);
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (pop_s[i] && !rst) rd[i] <= rd[i] + 1;
        end
    end

    // Scoreboard: every accepted literal must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sched_valid && sched_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL accept_extra: got lit %0d idx %0d, required none",
                         sched_lit, grant_idx);
            end else begin
                e = expq.pop_front();
                checks++;
                if (sched_lit !== e.lit) begin
                    errors++;
                    $display("FAIL sb_lit: got %0d, required %0d", sched_lit, e.lit);
                end
                checks++;
                if (grant_idx !== e.idx) begin
                    errors++;
                    $display("FAIL sb_idx: got %0d, required %0d", grant_idx, e.idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic lit_t mk(int e, int r);
        int v;
        v = e * 10 + r + 1;
        if (r % 2 == 1) v = -v;
        return lit_t'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int e, input lit_t v);
        mem[e][wr[e][5:0]] = v;
        wr[e]++;
    endtask

    task automatic push(input lit_t v, input int e);
        exp_t x;
        x.lit = v;
        x.idx = 2'(e);
        expq.push_back(x);
    endtask

    task automatic wait_drain(input int max, input string name);
        int n = 0;
        while (expq.size() != 0 && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d literals outstanding, required 0",
                     name, expq.size());
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({eng_pop, sched_valid, sched_lit, grant_idx, done, aborted} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: pop %b v %b lit %0d g %0d d %b a %b, required 0",
                     eng_pop, sched_valid, sched_lit, grant_idx, done, aborted);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rr_order();
        eng_busy    = '1;
        sched_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int e = 0; e < N; e++) begin
                load(e, mk(e, r));
                push(mk(e, r), e);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (sched_valid !== 1'b1 || grant_idx !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rr_tput: cycle %0d valid %b idx %0d, required 1 and %0d",
                         k, sched_valid, grant_idx, k % 4);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (sched_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_end: valid %b, required 0", sched_valid);
        end
        tick();
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL rr_left: %0d outstanding, required 0", expq.size());
        end
    endtask

    task automatic test_wrap();
        load(2, lit_t'(77));
        push(lit_t'(77), 2);
        wait_drain(20, "wrap_first");
        load(2, lit_t'(-88));
        push(lit_t'(-88), 2);
        wait_drain(20, "wrap_search");
        for (int e = 0; e < N; e++) load(e, lit_t'(100 + e));
        push(lit_t'(103), 3);
        push(lit_t'(100), 0);
        push(lit_t'(101), 1);
        push(lit_t'(102), 2);
        wait_drain(20, "wrap_pointer");
    endtask

    task automatic test_stall();
        sched_ready = 1'b0;
        load(3, lit_t'(-5));
        load(0, lit_t'(9));
        push(lit_t'(-5), 3);
        push(lit_t'(9), 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (sched_valid !== 1'b1 || sched_lit !== lit_t'(-5)) begin
                errors++;
                $display("FAIL stall_hold: valid %b lit %0d, required 1 and -5",
                         sched_valid, sched_lit);
            end
            checks++;
            if (eng_pop !== 4'b0000) begin
                errors++;
                $display("FAIL stall_pop: got %b, required 0000", eng_pop);
            end
            tick();
        end
        sched_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (eng_pop !== 4'b0001) begin
            errors++;
            $display("FAIL stall_release: pop %b, required 0001", eng_pop);
        end
        wait_drain(10, "stall_drain");
    endtask

    task automatic test_quiesce();
        load(1, lit_t'(33));
        push(lit_t'(33), 1);
        eng_busy = '0;
        tick();
        tick();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'(k == 6) || aborted !== 1'b0) begin
                errors++;
                $display("FAIL quiesce: cycle %0d done %b aborted %b, required %b and 0",
                         k, done, aborted, k == 6);
            end
            tick();
        end
    endtask

    task automatic test_quiesce_blip();
        eng_busy = '1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL restart: done %b aborted %b, required 0 and 0", done, aborted);
        end
        tick();
        load(0, lit_t'(-21));
        push(lit_t'(-21), 0);
        eng_busy = '0;
        tick();
        tick();
        tick();
        eng_busy = 4'b0010;
        tick();
        eng_busy = '0;
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'(k == 8)) begin
                errors++;
                $display("FAIL blip: cycle %0d done %b, required %b", k, done, k == 8);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        eng_busy = '1;
        start    = 1'b1;
        tick();
        start       = 1'b0;
        sched_ready = 1'b0;
        load(0, lit_t'(55));
        load(1, lit_t'(66));
        tick();
        abort       = 1'b1;
        start       = 1'b1;
        sched_ready = 1'b1;
        push(lit_t'(55), 0);
        @(negedge clk);
        checks++;
        if (eng_pop !== 4'b0000) begin
            errors++;
            $display("FAIL abort_pop: got %b, required 0000", eng_pop);
        end
        tick();
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (sched_valid !== 1'b0 || done !== 1'b1 || aborted !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: valid %b done %b aborted %b, required 0 1 1",
                     sched_valid, done, aborted);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (eng_pop !== 4'b0000) begin
                errors++;
                $display("FAIL abort_hold: got %b, required 0000", eng_pop);
            end
        end
        tick();
        push(lit_t'(66), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (aborted !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: aborted %b done %b, required 0 and 0",
                     aborted, done);
        end
        tick();
        wait_drain(10, "abort_drain");
    endtask

    task automatic test_rst_mid();
        sched_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int e = 0; e < N; e++) load(e, mk(e, r));
            for (int k = 0; k < N; k++) push(mk((2 + k) % N, r), (2 + k) % N);
        end
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({eng_pop, sched_valid, sched_lit, grant_idx, done, aborted} !== '0) begin
            errors++;
            $display("FAIL rst_mid: pop %b v %b lit %0d g %0d d %b a %b, required 0",
                     eng_pop, sched_valid, sched_lit, grant_idx, done, aborted);
        end
        expq.delete();
        tick();
        tick();
        for (int e = 0; e < N; e++) wr[e] = rd[e];
        rst = 1'b0;
        load(0, lit_t'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (eng_pop !== 4'b0000 || sched_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_idle: pop %b valid %b, required 0000 and 0",
                         eng_pop, sched_valid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_wrap();
        test_stall();
        test_quiesce();
        test_quiesce_blip();
        test_abort();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
